// File: rtl/packet_sender_mc.sv
// Multi-channel packet sender: round-robin picks a non-empty channel buffer and
// streams SRC, DST, SIZE, DATA words plus an XOR checksum over a valid/ready link.
module packet_sender_mc #(
  parameter int unsigned UWIDTH    = 8,
  parameter int unsigned PTR_IN_SZ = 4,
  parameter int unsigned NCH       = 2,
  parameter int unsigned SIZE_BITS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          rempty,
  input  logic [NCH*UWIDTH-1:0]   rdata,
  output logic [PTR_IN_SZ-1:0]    raddr,
  output logic [NCH-1:0]          rinc,
  output logic [UWIDTH-1:0]       packet_out,
  output logic                    packet_valid,
  input  logic                    packet_ready,
  output logic                    packet_sop,
  output logic                    packet_eop,
  output logic [NCH-1:0]          grant
);

  localparam int unsigned LG_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SRC,
    S_DST,
    S_SIZE,
    S_DATA,
    S_CRC
  } state_t;

  state_t               state, state_nxt;
  logic [LG_W-1:0]      last_grant, last_grant_nxt;
  logic [NCH-1:0]       grant_nxt;
  logic [PTR_IN_SZ-1:0] raddr_nxt;
  logic [UWIDTH-1:0]    crc, crc_nxt;
  logic [SIZE_BITS-1:0] dsz, dsz_nxt;
  logic [UWIDTH-1:0]    sel_data;
  logic                 accept;
  logic                 arb_hit;
  logic [NCH-1:0]       arb_grant;
  logic [LG_W-1:0]      arb_idx;

  function automatic int unsigned wrap_idx(input int unsigned base, input int unsigned off);
    return (base + off) % NCH;
  endfunction

  // Round-robin search starting just above the previous winner.
  always_comb begin
    arb_hit   = 1'b0;
    arb_grant = '0;
    arb_idx   = last_grant;
    for (int unsigned i = 1; i <= NCH; i++) begin
      if (!arb_hit && !rempty[wrap_idx(32'(last_grant), i)]) begin
        arb_hit = 1'b1;
        arb_grant[wrap_idx(32'(last_grant), i)] = 1'b1;
        arb_idx = LG_W'(wrap_idx(32'(last_grant), i));
      end
    end
  end

  // Granted channel's buffer word at raddr.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant[i]) sel_data = sel_data | rdata[i*UWIDTH +: UWIDTH];
    end
  end

  // Outputs are forced low during reset so a pending beat cannot leak out.
  assign packet_valid = (state != S_IDLE) && !rst;
  assign packet_sop   = (state == S_SRC) && !rst;
  assign packet_eop   = (state == S_CRC) && !rst;
  assign accept       = packet_valid && packet_ready;
  assign packet_out   = (state == S_CRC) ? crc : sel_data;
  assign rinc         = (packet_eop && packet_ready) ? grant : '0;

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    raddr_nxt      = raddr;
    crc_nxt        = crc;
    dsz_nxt        = dsz;
    case (state)
      S_IDLE: begin
        if (arb_hit) begin
          state_nxt      = S_SRC;
          grant_nxt      = arb_grant;
          last_grant_nxt = arb_idx;
          raddr_nxt      = '0;
          crc_nxt        = '0;
        end
      end
      S_SRC: begin
        if (accept) begin
          state_nxt = S_DST;
          crc_nxt   = crc ^ sel_data;
          raddr_nxt = raddr + PTR_IN_SZ'(1);
        end
      end
      S_DST: begin
        if (accept) begin
          state_nxt = S_SIZE;
          crc_nxt   = crc ^ sel_data;
          raddr_nxt = raddr + PTR_IN_SZ'(1);
        end
      end
      S_SIZE: begin
        if (accept) begin
          crc_nxt   = crc ^ sel_data;
          raddr_nxt = raddr + PTR_IN_SZ'(1);
          dsz_nxt   = sel_data[SIZE_BITS-1:0];
          state_nxt = (sel_data[SIZE_BITS-1:0] != '0) ? S_DATA : S_CRC;
        end
      end
      S_DATA: begin
        if (accept) begin
          crc_nxt   = crc ^ sel_data;
          raddr_nxt = raddr + PTR_IN_SZ'(1);
          dsz_nxt   = dsz - SIZE_BITS'(1);
          if (dsz == SIZE_BITS'(1)) state_nxt = S_CRC;
        end
      end
      S_CRC: begin
        if (accept) begin
          state_nxt = S_IDLE;
          grant_nxt = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= LG_W'(NCH - 1);
      raddr      <= '0;
      crc        <= '0;
      dsz        <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      raddr      <= raddr_nxt;
      crc        <= crc_nxt;
      dsz        <= dsz_nxt;
    end
  end

endmodule

// File: tb/tb_packet_sender_mc.sv
// Directed bench for packet_sender_mc: two channel buffers modelled as small
// arrays, outputs sampled on the falling clock edge.
module tb_packet_sender_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rempty;
  logic [15:0] rdata;
  logic [3:0]  raddr;
  logic [1:0]  rinc;
  logic [7:0]  packet_out;
  logic        packet_valid;
  logic        packet_ready;
  logic        packet_sop;
  logic        packet_eop;
  logic [1:0]  grant;

  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign rdata = {mem1[raddr], mem0[raddr]};

  packet_sender_mc #(.UWIDTH(8), .PTR_IN_SZ(4), .NCH(2), .SIZE_BITS(3)) dut (
    .clk(clk), .rst(rst), .rempty(rempty), .rdata(rdata), .raddr(raddr),
    .rinc(rinc), .packet_out(packet_out), .packet_valid(packet_valid),
    .packet_ready(packet_ready), .packet_sop(packet_sop), .packet_eop(packet_eop),
    .grant(grant)
  );

  task automatic load_basic0();
    for (int i = 0; i < 16; i++) mem0[i] = 8'hFF;
    mem0[0] = 8'h11; mem0[1] = 8'h22; mem0[2] = 8'h02; mem0[3] = 8'hA0; mem0[4] = 8'h0B;
  endtask

  task automatic load_ch1();
    for (int i = 0; i < 16; i++) mem1[i] = 8'hEE;
    mem1[0] = 8'h55; mem1[1] = 8'h66; mem1[2] = 8'h01; mem1[3] = 8'h77;
  endtask

  // Bounded wait for the start of a packet.
  task automatic wait_sop(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (packet_sop === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rempty = 2'b00; packet_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (packet_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", packet_valid); end
    n_checks++;
    if (rinc !== 2'b00) begin n_fail++; $display("FAIL reset_rinc got %b exp 00", rinc); end
    n_checks++;
    if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant got %b exp 00", grant); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (grant !== 2'b01 || packet_sop !== 1'b1) begin
      n_fail++; $display("FAIL reset_first_grant got grant=%b sop=%b exp grant=01 sop=1", grant, packet_sop);
    end
    rst = 1'b1; rempty = 2'b11;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [6];
    exp_b = '{8'h11, 8'h22, 8'h02, 8'hA0, 8'h0B, 8'h9A};
    load_basic0();
    rempty = 2'b10;
    @(negedge clk);
    rempty = 2'b11;
    n_checks++;
    if (raddr !== 4'd0) begin n_fail++; $display("FAIL basic_raddr0 got %0d exp 0", raddr); end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (packet_valid !== 1'b1 || packet_out !== exp_b[k]) begin
        n_fail++; $display("FAIL basic_beat%0d got valid=%b out=%h exp valid=1 out=%h", k, packet_valid, packet_out, exp_b[k]);
      end
      n_checks++;
      if (packet_sop !== (k == 0) || packet_eop !== (k == 5)) begin
        n_fail++; $display("FAIL basic_marks%0d got sop=%b eop=%b exp sop=%b eop=%b", k, packet_sop, packet_eop, k == 0, k == 5);
      end
      n_checks++;
      if (rinc !== ((k == 5) ? 2'b01 : 2'b00)) begin
        n_fail++; $display("FAIL basic_rinc%0d got %b exp %b", k, rinc, (k == 5) ? 2'b01 : 2'b00);
      end
      @(negedge clk);
    end
    n_checks++;
    if (packet_valid !== 1'b0 || grant !== 2'b00) begin
      n_fail++; $display("FAIL basic_idle got valid=%b grant=%b exp valid=0 grant=00", packet_valid, grant);
    end
  endtask

  task automatic test_size0();
    logic [7:0] exp_b [4];
    exp_b = '{8'h01, 8'h02, 8'h00, 8'h03};
    for (int i = 0; i < 16; i++) mem0[i] = 8'hFF;
    mem0[0] = 8'h01; mem0[1] = 8'h02; mem0[2] = 8'h00;
    rempty = 2'b10;
    @(negedge clk);
    rempty = 2'b11;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (packet_valid !== 1'b1 || packet_out !== exp_b[k] || packet_eop !== (k == 3)) begin
        n_fail++; $display("FAIL size0_beat%0d got valid=%b out=%h eop=%b exp valid=1 out=%h eop=%b",
                           k, packet_valid, packet_out, packet_eop, exp_b[k], k == 3);
      end
      @(negedge clk);
    end
    n_checks++;
    if (packet_valid !== 1'b0) begin n_fail++; $display("FAIL size0_end got valid=%b exp 0", packet_valid); end
  endtask

  task automatic test_stall();
    logic [7:0] exp_b [6];
    exp_b = '{8'h11, 8'h22, 8'h02, 8'hA0, 8'h0B, 8'h9A};
    load_basic0();
    rempty = 2'b10;
    @(negedge clk);
    rempty = 2'b11;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (packet_out !== exp_b[k]) begin
        n_fail++; $display("FAIL stall_beat%0d got %h exp %h", k, packet_out, exp_b[k]);
      end
      if (k == 3) begin
        packet_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
          @(negedge clk);
          n_checks++;
          if (packet_out !== 8'hA0 || raddr !== 4'd3 || packet_valid !== 1'b1 || rinc !== 2'b00) begin
            n_fail++; $display("FAIL stall_hold%0d got out=%h raddr=%0d valid=%b rinc=%b exp out=a0 raddr=3 valid=1 rinc=00",
                               s, packet_out, raddr, packet_valid, rinc);
          end
        end
        packet_ready = 1'b1;
      end
      @(negedge clk);
    end
    n_checks++;
    if (packet_valid !== 1'b0) begin n_fail++; $display("FAIL stall_end got valid=%b exp 0", packet_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [4];
    logic [7:0] exp_c [4];
    int         exp_len [4];
    bit         ok;
    int         cnt;
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_c = '{8'h9A, 8'h45, 8'h9A, 8'h45};
    exp_len = '{6, 5, 6, 5};
    load_basic0();
    load_ch1();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rempty = 2'b00;
    for (int p = 0; p < 4; p++) begin
      wait_sop(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rr_sop%0d got timeout exp sop", p); end
      n_checks++;
      if (grant !== exp_g[p]) begin n_fail++; $display("FAIL rr_grant%0d got %b exp %b", p, grant, exp_g[p]); end
      cnt = 0;
      while (packet_eop !== 1'b1 && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      n_checks++;
      if (cnt != exp_len[p] - 1) begin n_fail++; $display("FAIL rr_len%0d got %0d exp %0d", p, cnt + 1, exp_len[p]); end
      n_checks++;
      if (rinc !== exp_g[p] || packet_out !== exp_c[p]) begin
        n_fail++; $display("FAIL rr_eop%0d got rinc=%b crc=%h exp rinc=%b crc=%h", p, rinc, packet_out, exp_g[p], exp_c[p]);
      end
      @(negedge clk);
      if (p == 3) rempty = 2'b11;
      n_checks++;
      if (packet_valid !== 1'b0 || rinc !== 2'b00) begin
        n_fail++; $display("FAIL rr_gap%0d got valid=%b rinc=%b exp valid=0 rinc=00", p, packet_valid, rinc);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_b [5];
    bit         ok;
    int         cnt;
    exp_b = '{8'h55, 8'h66, 8'h01, 8'h77, 8'h45};
    rempty = 2'b01;
    wait_sop(ok);
    n_checks++;
    if (!ok || grant !== 2'b10) begin n_fail++; $display("FAIL mid_start got ok=%b grant=%b exp ok=1 grant=10", ok, grant); end
    rempty = 2'b00;
    repeat (3) @(negedge clk);
    n_checks++;
    if (packet_out !== 8'h77) begin n_fail++; $display("FAIL mid_data got %h exp 77", packet_out); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (packet_valid !== 1'b0 || rinc !== 2'b00) begin
      n_fail++; $display("FAIL mid_in_reset got valid=%b rinc=%b exp valid=0 rinc=00", packet_valid, rinc);
    end
    @(negedge clk);
    n_checks++;
    if (packet_valid !== 1'b0 || rinc !== 2'b00 || grant !== 2'b00) begin
      n_fail++; $display("FAIL mid_after got valid=%b rinc=%b grant=%b exp 0/00/00", packet_valid, rinc, grant);
    end
    rst = 1'b0;
    wait_sop(ok);
    n_checks++;
    if (!ok || grant !== 2'b01) begin n_fail++; $display("FAIL mid_ch0_first got ok=%b grant=%b exp ok=1 grant=01", ok, grant); end
    cnt = 0;
    while (packet_eop !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (rinc !== 2'b01) begin n_fail++; $display("FAIL mid_ch0_rinc got %b exp 01", rinc); end
    @(negedge clk);
    wait_sop(ok);
    rempty = 2'b11;
    n_checks++;
    if (!ok || grant !== 2'b10) begin n_fail++; $display("FAIL mid_ch1_resend got ok=%b grant=%b exp ok=1 grant=10", ok, grant); end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (packet_out !== exp_b[k] || rinc !== ((k == 4) ? 2'b10 : 2'b00)) begin
        n_fail++; $display("FAIL mid_resend_beat%0d got out=%h rinc=%b exp out=%h rinc=%b",
                           k, packet_out, rinc, exp_b[k], (k == 4) ? 2'b10 : 2'b00);
      end
      @(negedge clk);
    end
    n_checks++;
    if (packet_valid !== 1'b0) begin n_fail++; $display("FAIL mid_end got valid=%b exp 0", packet_valid); end
  endtask

  initial begin
    rst = 1'b1;
    rempty = 2'b00;
    packet_ready = 1'b1;
    load_basic0();
    load_ch1();
    test_reset();
    test_basic();
    test_size0();
    test_stall();
    test_round_robin();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_sender_mc.md
PACKET_SENDER_MC -- requirements
Module: packet_sender_mc

Interface
REQ-001 SHALL have parameter UWIDTH, default 8, meaning width of one packet word in bits.
REQ-002 SHALL have parameter PTR_IN_SZ, default 4, meaning width of the buffer read address.
REQ-003 SHALL have parameter NCH, default 2, meaning the number of input channel buffers, with NCH >= 2.
REQ-004 SHALL have parameter SIZE_BITS, default 3, meaning width of the payload-length field, with 3 + 2^SIZE_BITS - 1 <= 2^PTR_IN_SZ.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-007 SHALL have port rempty, input, NCH bits, where bit i high means channel i holds no complete packet.
REQ-008 SHALL have port rdata, input, NCH*UWIDTH bits, carrying channel i buffer contents at raddr in slice i, read combinationally.
REQ-009 SHALL have port raddr, output, PTR_IN_SZ bits, the shared read address for all channel buffers.
REQ-010 SHALL have port rinc, output, NCH bits, a one-hot, one-cycle packet-pop strobe to the granted channel.
REQ-011 SHALL have port packet_out, output, UWIDTH bits, the current output word.
REQ-012 SHALL have port packet_valid, output, 1 bit, high when packet_out holds a beat.
REQ-013 SHALL have port packet_ready, input, 1 bit, the downstream accept signal; a beat transfers when packet_valid and packet_ready are both high.
REQ-014 SHALL have ports packet_sop and packet_eop, output, 1 bit each, marking the first and last beat of a packet.
REQ-015 SHALL have port grant, output, NCH bits, the registered one-hot channel currently being sent; it is 0 in IDLE.

Function
REQ-016 SHALL read buffer packets laid out as: addr 0 SRC, addr 1 DST, addr 2 SIZE, addr 3..3+N-1 DATA, where N = SIZE[SIZE_BITS-1:0] and the upper SIZE bits are ignored.
REQ-017 SHALL implement the states IDLE, SRC, DST, SIZE, DATA and CRC.
REQ-018 In IDLE, if any rempty bit is low, SHALL grant the first non-empty channel searching upward from last_grant+1 with wrap-around, load last_grant, set raddr=0 and crc=0, and go to SRC; otherwise SHALL stay in IDLE.
REQ-019 SHALL sample rempty only in IDLE; changes to rempty during a packet SHALL be ignored.
REQ-020 SHALL drive packet_valid high in SRC, DST, SIZE, DATA and CRC, and low in IDLE.
REQ-021 In SRC through DATA, packet_out SHALL equal the granted slice of rdata; in CRC it SHALL equal crc.
REQ-022 SHALL hold state, raddr, crc and packet_out stable while packet_valid is high and packet_ready is low.
REQ-023 On each accepted beat in SRC through DATA, SHALL set crc <= crc XOR packet_out and increment raddr.
REQ-024 On SRC accept SHALL go to DST; on DST accept SHALL go to SIZE.
REQ-025 On SIZE accept SHALL load dsz from the size field, then go to DATA if that value is nonzero or to CRC if it is zero.
REQ-026 On DATA accept SHALL decrement dsz, and SHALL go to CRC when dsz was 1.
REQ-027 On CRC accept SHALL pulse rinc[grant] for exactly that cycle and go to IDLE.
REQ-028 SHALL hold packet_sop high only in SRC and packet_eop high only in CRC.
REQ-029 A packet SHALL take N+4 accepted beats, followed by at least one IDLE cycle; with packet_ready held high, packets SHALL start every N+5 cycles.
REQ-030 SHALL assert rinc on no channel other than the granted one, and never outside CRC.

Reset
REQ-031 With rst high at a clock edge, SHALL set state=IDLE, grant=0, last_grant=NCH-1 (so channel 0 wins first), raddr=0, crc=0 and dsz=0.
REQ-032 While in reset, packet_valid, packet_sop, packet_eop and rinc SHALL be 0.
REQ-033 A reset mid-packet SHALL abandon the packet without a rinc pulse; the channel's packet remains in its buffer and is re-sent after reset.

Verification
REQ-034 Hold rst high for 1 cycle with all rempty low -> after the edge: packet_valid=0, rinc=0, grant=0; the first grant is channel 0.
REQ-035 Channel 0 holds 11,22,02,A0,0B with ready=1 -> beats 11,22,02,A0,0B,9A on consecutive cycles; sop on 11, eop and rinc=01 on 9A.
REQ-036 Size-0 packet 01,02,00 -> beats 01,02,00,03; the DATA state is never entered.
REQ-037 Drop packet_ready for 2 cycles on the first DATA beat -> packet_out, raddr and crc are held; the sequence resumes unchanged.
REQ-038 Both channels are continuously non-empty -> grant sequence is 01,10,01,10; each rinc pulse matches its grant.
REQ-039 Assert rst during DATA of a channel-1 packet -> the next cycle is IDLE with no rinc pulse; after reset, channel 0 is served first, then channel 1's packet is re-sent intact.
